// File: rtl/ti_gf22mul_dom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ti_gf22mul_dom_pkg
// Description : Shared widths and types for the masked GF(2^2) multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package ti_gf22mul_dom_pkg;

    localparam int GF22_W = 2;
    localparam int SHARES = 2;

    typedef logic [GF22_W-1:0] gf22_t;

    typedef struct packed {
        logic s1;
        logic s2;
    } stage_valid_t;

endpackage
`default_nettype wire

// File: rtl/ti_gf22mul_dom_if.sv
`default_nettype none
// ============================================================================
// Module      : ti_gf22mul_dom_if
// Description : Operand/result handshake bundle for the masked multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface ti_gf22mul_dom_if;
    import ti_gf22mul_dom_pkg::*;

    gf22_t x0;
    gf22_t x1;
    gf22_t y0;
    gf22_t y1;
    gf22_t rnd;
    logic  rnd_valid;
    logic  in_valid;
    logic  in_ready;
    gf22_t z0;
    gf22_t z1;
    logic  out_valid;
    logic  out_ready;
    logic  busy;

    modport master (
        output x0, x1, y0, y1, rnd, rnd_valid, in_valid, out_ready,
        input  in_ready, z0, z1, out_valid, busy
    );

    modport slave (
        input  x0, x1, y0, y1, rnd, rnd_valid, in_valid, out_ready,
        output in_ready, z0, z1, out_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/gf22mul.sv
`default_nettype none
// ============================================================================
// Module      : gf22mul
// Description : Combinational normal-basis GF(2^2) multiplier (11 = one).
// Revision    : 1.0 - initial release
// ============================================================================
module gf22mul
    import ti_gf22mul_dom_pkg::*;
(
    input  gf22_t a,
    input  gf22_t b,
    output gf22_t p
);

    logic  w_p2;
    gf22_t w_pl;

    assign w_p2 = ~((^a) & (^b));
    assign w_pl = ~(a & b);
    assign p    = {w_p2 ^ w_pl[1], w_p2 ^ w_pl[0]};

endmodule
`default_nettype wire

// File: rtl/ti_gf22mul_dom.sv
`default_nettype none
// ============================================================================
// Module      : ti_gf22mul_dom
// Description : Two-stage domain-oriented masked GF(2^2) multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module ti_gf22mul_dom
    import ti_gf22mul_dom_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    ti_gf22mul_dom_if.slave bus
);

    gf22_t        w_x     [SHARES];
    gf22_t        w_y     [SHARES];
    gf22_t        w_dom   [SHARES];
    gf22_t        w_cross [SHARES];

    stage_valid_t r_vld;
    gf22_t        r_dom   [SHARES];
    gf22_t        r_cross [SHARES];
    gf22_t        r_z     [SHARES];

    logic         w_s2_ready;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_s2_load;

    assign w_x[0] = bus.x0;
    assign w_x[1] = bus.x1;
    assign w_y[0] = bus.y0;
    assign w_y[1] = bus.y1;

    // Share i owns the in-domain product and the cross term x_i * y_(other).
    generate
        for (genvar i = 0; i < SHARES; i++) begin : g_share
            gf22mul u_dom (
                .a (w_x[i]),
                .b (w_y[i]),
                .p (w_dom[i])
            );
            gf22mul u_cross (
                .a (w_x[i]),
                .b (w_y[SHARES-1-i]),
                .p (w_cross[i])
            );
        end
    endgenerate

    assign w_s2_ready = !r_vld.s2 || bus.out_ready;
    assign w_in_ready = !r_vld.s1 || w_s2_ready;
    assign w_accept   = bus.in_valid && w_in_ready && bus.rnd_valid;
    assign w_s2_load  = r_vld.s1 && w_s2_ready;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_vld <= '0;
            for (int i = 0; i < SHARES; i++) begin
                r_dom[i]   <= '0;
                r_cross[i] <= '0;
                r_z[i]     <= '0;
            end
        end else begin
            // Cross terms are refreshed before being registered so no share mix reaches stage 2 raw.
            if (w_accept) begin
                for (int i = 0; i < SHARES; i++) begin
                    r_dom[i]   <= w_dom[i];
                    r_cross[i] <= w_cross[i] ^ bus.rnd;
                end
            end

            if (w_accept) begin
                r_vld.s1 <= 1'b1;
            end else if (w_s2_ready) begin
                r_vld.s1 <= 1'b0;
            end

            if (w_s2_load) begin
                for (int i = 0; i < SHARES; i++) begin
                    r_z[i] <= r_dom[i] ^ r_cross[i];
                end
            end

            if (w_s2_ready) begin
                r_vld.s2 <= r_vld.s1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld.s2;
    assign bus.busy      = r_vld.s1 || r_vld.s2;
    assign bus.z0        = r_z[0];
    assign bus.z1        = r_z[1];

endmodule
`default_nettype wire
